// File: rtl/seat_table.sv
// seat_table -- seat-assignment table with duplicate-student detection.
//
// Each of SEATS entries holds a student number plus an occupied bit. One
// request is in flight at a time. Assign scans the whole table, one entry per
// cycle, for the same student number before it commits. Release, lookup,
// clear-all and out-of-range seats all respond one cycle after acceptance.
//
// Ports
//   clk_seat, reset_seat         clock; asynchronous active-high reset
//   req_valid / req_ready        request handshake (ready only in IDLE)
//   req_op                       00 assign, 01 release, 10 lookup, 11 clear-all
//   req_seat, req_student        target seat and student number
//   rsp_valid                    one-cycle response pulse
//   rsp_status                   0 OK, 1 SEAT_TAKEN, 2 DUP_STUDENT, 3 BAD_SEAT, 4 EMPTY
//   rsp_student                  stored number (release/lookup), otherwise 0
//   occ_count, full              occupancy count and count == SEATS
module seat_table #(
   parameter int SEATS  = 32,
   parameter int SNO_W  = 25,
   parameter int SEAT_W = 8
) (
   input  logic              clk_seat,
   input  logic              reset_seat,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [1:0]        req_op,
   input  logic [SEAT_W-1:0] req_seat,
   input  logic [SNO_W-1:0]  req_student,
   output logic              rsp_valid,
   output logic [2:0]        rsp_status,
   output logic [SNO_W-1:0]  rsp_student,
   output logic [SEAT_W:0]   occ_count,
   output logic              full
);

   localparam int IDX_W = (SEATS > 2) ? $clog2(SEATS) : 1;

   localparam logic [SEAT_W:0] SEATS_V = (SEAT_W + 1)'(SEATS);
   localparam logic [SEAT_W:0] CNT_ONE = (SEAT_W + 1)'(1);
   localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SEATS - 1);

   localparam logic [1:0] OP_ASSIGN  = 2'd0;
   localparam logic [1:0] OP_RELEASE = 2'd1;
   localparam logic [1:0] OP_CLEAR   = 2'd3;

   localparam logic [2:0] ST_OK    = 3'd0;
   localparam logic [2:0] ST_TAKEN = 3'd1;
   localparam logic [2:0] ST_DUP   = 3'd2;
   localparam logic [2:0] ST_BAD   = 3'd3;
   localparam logic [2:0] ST_EMPTY = 3'd4;

   typedef enum logic [1:0] {IDLE, SCAN, COMMIT, RESP} state_t;

   state_t             state_q;
   logic [IDX_W-1:0]   seat_q;
   logic [SNO_W-1:0]   stu_q;
   logic [IDX_W-1:0]   idx_q;
   logic               dup_q;
   logic [SEATS-1:0]   occ_q;
   logic [SEAT_W:0]    count_q;
   logic               rsp_valid_q;
   logic [2:0]         rsp_status_q;
   logic [SNO_W-1:0]   rsp_student_q;
   logic [SNO_W-1:0]   data_q [SEATS];

   logic               accept;
   logic               bad_seat;
   logic [IDX_W-1:0]   req_idx;
   logic               scan_hit;
   logic               commit_wr;

   assign req_ready = (state_q == IDLE) && !reset_seat;
   assign accept    = req_valid && req_ready;
   assign req_idx   = req_seat[IDX_W-1:0];
   // Range check uses the full seat field, not the truncated index.
   assign bad_seat  = {1'b0, req_seat} >= SEATS_V;
   assign scan_hit  = occ_q[idx_q] && (data_q[idx_q] == stu_q);
   assign commit_wr = (state_q == COMMIT) && !occ_q[seat_q] && !dup_q;

   assign rsp_valid   = rsp_valid_q;
   assign rsp_status  = rsp_status_q;
   assign rsp_student = rsp_student_q;
   assign occ_count   = count_q;
   assign full        = (count_q == SEATS_V);

   // Entry data carries no reset; validity lives in occ_q. A reset forces
   // state_q to IDLE asynchronously, so commit_wr cannot fire under reset.
   always_ff @(posedge clk_seat) begin
      if (commit_wr) data_q[seat_q] <= stu_q;
   end

   always_ff @(posedge clk_seat or posedge reset_seat) begin
      if (reset_seat) begin
         state_q       <= IDLE;
         seat_q        <= '0;
         stu_q         <= '0;
         idx_q         <= '0;
         dup_q         <= 1'b0;
         occ_q         <= '0;
         count_q       <= '0;
         rsp_valid_q   <= 1'b0;
         rsp_status_q  <= ST_OK;
         rsp_student_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept) begin
                  seat_q        <= req_idx;
                  stu_q         <= req_student;
                  idx_q         <= '0;
                  dup_q         <= 1'b0;
                  rsp_status_q  <= ST_OK;
                  rsp_student_q <= '0;
                  rsp_valid_q   <= 1'b1;
                  state_q       <= RESP;
                  if (req_op == OP_CLEAR) begin
                     occ_q   <= '0;
                     count_q <= '0;
                  end else if (bad_seat) begin
                     rsp_status_q <= ST_BAD;
                  end else if (req_op == OP_ASSIGN) begin
                     // Long path: no response until COMMIT decides.
                     rsp_valid_q <= 1'b0;
                     state_q     <= SCAN;
                  end else if (!occ_q[req_idx]) begin
                     rsp_status_q <= ST_EMPTY;
                  end else begin
                     rsp_student_q <= data_q[req_idx];
                     if (req_op == OP_RELEASE) begin
                        occ_q[req_idx] <= 1'b0;
                        count_q        <= count_q - CNT_ONE;
                     end
                  end
               end
            end
            SCAN: begin
               if (scan_hit) dup_q <= 1'b1;
               idx_q <= idx_q + IDX_ONE;
               if (idx_q == IDX_LAST) state_q <= COMMIT;
            end
            COMMIT: begin
               // Occupied target outranks a duplicate; a full table always
               // lands here as SEAT_TAKEN.
               if (occ_q[seat_q]) begin
                  rsp_status_q <= ST_TAKEN;
               end else if (dup_q) begin
                  rsp_status_q <= ST_DUP;
               end else begin
                  occ_q[seat_q] <= 1'b1;
                  count_q       <= count_q + CNT_ONE;
                  rsp_status_q  <= ST_OK;
               end
               rsp_student_q <= '0;
               rsp_valid_q   <= 1'b1;
               state_q       <= RESP;
            end
            default: begin
               rsp_valid_q <= 1'b0;
               state_q     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/seat_table.md
SEAT_TABLE -- requirements
Module: seat_table

Interface
REQ-001 Parameter SEATS, default 32, number of seat entries (2..256).
REQ-002 Parameter SNO_W, default 25, student-number width in bits.
REQ-003 Parameter SEAT_W, default 8, seat-index width; 2**SEAT_W >= SEATS.
REQ-004 clk_seat  input  1  single clock; all state changes on its rising edge.
REQ-005 reset_seat  input  1  reset, asynchronous, active-high.
REQ-006 req_valid  input  1  request present.
REQ-007 req_ready  output  1  block accepts a request this cycle.
REQ-008 req_op  input  2  00 assign, 01 release, 10 lookup, 11 clear-all.
REQ-009 req_seat  input  SEAT_W  target seat index.
REQ-010 req_student  input  SNO_W  student number for assign.
REQ-011 rsp_valid  output  1  one-cycle pulse; response fields valid.
REQ-012 rsp_status  output  3  0 OK, 1 SEAT_TAKEN, 2 DUP_STUDENT, 3 BAD_SEAT, 4 EMPTY.
REQ-013 rsp_student  output  SNO_W  student number held by the seat (lookup and release), else 0.
REQ-014 occ_count  output  SEAT_W+1  number of occupied seats.
REQ-015 full  output  1  high when occ_count == SEATS.

Function
REQ-016 Each entry SHALL hold a SNO_W student number plus an occupied bit; student number 0 is a legal value.
REQ-017 Requests SHALL be accepted on a rising edge with req_valid && req_ready; req_ready SHALL be high only in IDLE.
REQ-018 FSM states SHALL be IDLE, SCAN, COMMIT, RESP; only one request in flight; rsp_valid high only in RESP, for exactly one cycle, then IDLE; no backpressure on the response.
REQ-019 req_seat >= SEATS for op 00/01/10 SHALL give BAD_SEAT with no state change, rsp_valid the cycle after acceptance.
REQ-020 Assign, valid seat: SCAN SHALL visit indices 0..SEATS-1 one per cycle, flagging any occupied entry whose number equals req_student; COMMIT then decides; rsp_valid SHALL assert SEATS+2 cycles after acceptance.
REQ-021 COMMIT priority: target occupied -> SEAT_TAKEN; else duplicate found -> DUP_STUDENT; else write entry, set occupied, increment occ_count, OK.
REQ-022 Release: occupied seat -> clear occupied, decrement occ_count, return old number, OK; empty seat -> EMPTY, no change; rsp_valid 1 cycle after acceptance.
REQ-023 Lookup: occupied -> OK with stored number; empty -> EMPTY, rsp_student 0; no state change; 1-cycle latency.
REQ-024 Clear-all: all occupied bits and occ_count SHALL clear on the acceptance edge; OK, 1-cycle latency.
REQ-025 Request fields SHALL be registered at acceptance; input changes during SCAN SHALL not affect the result.
REQ-026 occ_count SHALL never exceed SEATS nor underflow; full is combinational from occ_count.
REQ-027 Assign when full SHALL return SEAT_TAKEN (target necessarily occupied).

Reset
REQ-028 reset_seat high SHALL immediately force IDLE, clear all occupied bits, occ_count=0, full=0, rsp_valid=0, rsp_status=0, rsp_student=0, req_ready low while asserted.
REQ-029 Reset during SCAN/COMMIT SHALL drop the in-flight request with no response and no table write; entry data bits need not reset.
REQ-030 First request SHALL be accepted on the first rising edge after reset deasserts.

Verification (SEATS=32)
REQ-031 Assign seat 5 student 0x1234567 -> rsp_valid 34 cycles after accept, OK, occ_count=1; lookup 5 -> OK, 0x1234567.
REQ-032 Assign seat 6 same student -> DUP_STUDENT; assign seat 5 student 0x42 -> SEAT_TAKEN; occ_count stays 1.
REQ-033 Lookup/assign seat 40 -> BAD_SEAT after 1 cycle; release empty seat 7 -> EMPTY, rsp_student 0.
REQ-034 Fill seats 0..31 with distinct numbers -> full=1, occ_count=32; release seat 31 -> OK, old number, full=0; clear-all -> occ_count=0.
REQ-035 Assert reset_seat mid-SCAN -> no rsp_valid, req_ready high after deassert, lookup of target -> EMPTY, occ_count=0.
REQ-036 Toggle req_student/req_seat during SCAN -> result reflects values captured at acceptance.
